// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: controller state encoding, PC width and the
// NOP word that the stage registers load on a flush or a bubble.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    DRAIN      = 2'd2,
    HALTED     = 2'd3
  } state_t;

  localparam int unsigned PC_W = 8;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: arbitrates redirects, load-use stalls and
// halt drain, and keeps saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW          = 4,
  parameter int unsigned LOAD_USE_STALLS = 1,
  parameter int unsigned DRAIN_CYCLES    = 3,
  parameter int unsigned CNT_W           = 16
) (
  input  logic              clkwire,
  input  logic              rstwire,
  input  logic              ex_branch_taken,
  input  logic [PC_W-1:0]   ex_branch_target,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_is_halt,
  output logic              pc_enable,
  output logic              if_id_enable,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              jump_selector,
  output logic [PC_W-1:0]   jump_address,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  state_t     state;
  logic [2:0] remain;
  logic       lu;
  logic       redirect;
  logic       stall_inc;

  assign lu = ex_is_load &
              ((id_uses_rs1 & (id_rs1 == ex_rd)) |
               (id_uses_rs2 & (id_rs2 == ex_rd)));

  // HALTED ignores everything, including taken branches.
  assign redirect = ex_branch_taken & (state != HALTED);

  always_ff @(posedge clkwire or posedge rstwire) begin
    if (rstwire) begin
      state  <= RUN;
      remain <= '0;
    end else if (redirect) begin
      state  <= RUN;
      remain <= '0;
    end else begin
      case (state)
        RUN: begin
          if (lu) begin
            if (LOAD_USE_STALLS > 1) begin
              state  <= LOAD_STALL;
              remain <= 3'(LOAD_USE_STALLS - 1);
            end
          end else if (id_is_halt) begin
            if (DRAIN_CYCLES > 1) begin
              state  <= DRAIN;
              remain <= 3'(DRAIN_CYCLES - 1);
            end else begin
              state <= HALTED;
            end
          end
        end
        LOAD_STALL: begin
          if (remain == 3'd1) begin
            state  <= RUN;
            remain <= '0;
          end else begin
            remain <= remain - 3'd1;
          end
        end
        DRAIN: begin
          if (remain == 3'd1) begin
            state  <= HALTED;
            remain <= '0;
          end else begin
            remain <= remain - 3'd1;
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    jump_selector = 1'b0;
    jump_address  = '0;
    if (rstwire) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
    end else if (redirect) begin
      jump_selector = 1'b1;
      jump_address  = ex_branch_target;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
    end else if ((state != RUN) || lu || id_is_halt) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  assign halted    = (state == HALTED);
  assign stall_inc = ~rstwire & ~pc_enable & ((state == RUN) || (state == LOAD_STALL));

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clkwire),
    .rst   (rstwire),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clkwire),
    .rst   (rstwire),
    .inc   (redirect & ~rstwire),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default build, a 2-cycle load-use
// build and a 4-bit counter build all share one stimulus stream.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       br = 1'b0;
  logic [7:0] tgt = '0;
  logic       ld = 1'b0;
  logic [3:0] rd = '0, rs1 = '0, rs2 = '0;
  logic       u1 = 1'b0, u2 = 1'b0, hlt = 1'b0;

  logic        pc0, ie0, fl0, bb0, js0, h0;
  logic [7:0]  ja0;
  logic [15:0] sc0, fc0;
  logic        pc1, ie1, fl1, bb1, js1, h1;
  logic [7:0]  ja1;
  logic [15:0] sc1, fc1;
  logic        pc2, ie2, fl2, bb2, js2, h2;
  logic [7:0]  ja2;
  logic [3:0]  sc2, fc2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut0 (
    .clkwire(clk), .rstwire(rst), .ex_branch_taken(br), .ex_branch_target(tgt),
    .ex_is_load(ld), .ex_rd(rd), .id_rs1(rs1), .id_rs2(rs2),
    .id_uses_rs1(u1), .id_uses_rs2(u2), .id_is_halt(hlt),
    .pc_enable(pc0), .if_id_enable(ie0), .if_id_flush(fl0), .id_ex_bubble(bb0),
    .jump_selector(js0), .jump_address(ja0), .halted(h0),
    .stall_count(sc0), .flush_count(fc0));

  pipe_hazard_ctrl #(.LOAD_USE_STALLS(2)) dut1 (
    .clkwire(clk), .rstwire(rst), .ex_branch_taken(br), .ex_branch_target(tgt),
    .ex_is_load(ld), .ex_rd(rd), .id_rs1(rs1), .id_rs2(rs2),
    .id_uses_rs1(u1), .id_uses_rs2(u2), .id_is_halt(hlt),
    .pc_enable(pc1), .if_id_enable(ie1), .if_id_flush(fl1), .id_ex_bubble(bb1),
    .jump_selector(js1), .jump_address(ja1), .halted(h1),
    .stall_count(sc1), .flush_count(fc1));

  pipe_hazard_ctrl #(.CNT_W(4)) dut2 (
    .clkwire(clk), .rstwire(rst), .ex_branch_taken(br), .ex_branch_target(tgt),
    .ex_is_load(ld), .ex_rd(rd), .id_rs1(rs1), .id_rs2(rs2),
    .id_uses_rs1(u1), .id_uses_rs2(u2), .id_is_halt(hlt),
    .pc_enable(pc2), .if_id_enable(ie2), .if_id_flush(fl2), .id_ex_bubble(bb2),
    .jump_selector(js2), .jump_address(ja2), .halted(h2),
    .stall_count(sc2), .flush_count(fc2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and checks happen in the low phase.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    br = 1'b0; tgt = '0; ld = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
    u1 = 1'b0; u2 = 1'b0; hlt = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_lu();
    ld = 1'b1; rd = 4'd5; u2 = 1'b1; rs2 = 4'd5;
  endtask

  initial begin
    idle();
    #1;
    chk("rst_pc_enable", pc0, 0);
    chk("rst_if_id_enable", ie0, 0);
    chk("rst_halted", h0, 0);
    chk("rst_counts", {sc0, fc0}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("run_pc_enable", pc0, 1);
    chk("run_if_id_enable", ie0, 1);
    chk("run_bubble", bb0, 0);

    // Load-use hazard on rs2 for one cycle
    set_lu();
    #1;
    chk("lu_pc_enable", pc0, 0);
    chk("lu_bubble", bb0, 1);
    chk("lu_if_id_enable", ie0, 0);
    chk("lu2_pc_enable_c0", pc1, 0);
    tick();
    idle();
    #1;
    chk("lu_released", pc0, 1);
    chk("lu_stall_count", sc0, 1);
    chk("lu2_pc_enable_c1", pc1, 0);
    chk("lu2_bubble_c1", bb1, 1);
    tick();
    #1;
    chk("lu2_released", pc1, 1);
    chk("lu2_stall_count", sc1, 2);
    chk("lu_stall_count_hold", sc0, 1);

    // Register match but source not used, and a used-source mismatch
    ld = 1'b1; rd = 4'd5; rs2 = 4'd5; u2 = 1'b0; u1 = 1'b1; rs1 = 4'd6;
    #1;
    chk("nolu_pc_enable", pc0, 1);
    chk("nolu_bubble", bb0, 0);
    tick();
    idle();

    // Taken branch
    br = 1'b1; tgt = 8'h2A;
    #1;
    chk("br_jump_selector", js0, 1);
    chk("br_jump_address", ja0, 8'h2A);
    chk("br_flush", fl0, 1);
    chk("br_bubble", bb0, 1);
    chk("br_pc_enable", pc0, 1);
    tick();
    idle();
    #1;
    chk("br_flush_count", fc0, 1);
    chk("idle_jump_address", ja0, 0);
    chk("idle_jump_selector", js0, 0);

    // Redirect beats load-use and halt in the same cycle
    br = 1'b1; tgt = 8'h33; set_lu(); hlt = 1'b1;
    #1;
    chk("combo_pc_enable", pc0, 1);
    chk("combo_jump_address", ja0, 8'h33);
    chk("combo_lu2_pc_enable", pc1, 1);
    tick();
    idle();
    #1;
    chk("combo_state_run", pc0, 1);
    chk("combo_lu2_state_run", pc1, 1);
    chk("combo_not_halted", h0, 0);
    chk("combo_flush_count", fc0, 2);
    chk("combo_stall_count", sc0, 1);

    // Halt with three drain edges, then a branch that must be ignored
    hlt = 1'b1;
    #1;
    chk("halt_pc_enable", pc0, 0);
    chk("halt_bubble", bb0, 1);
    tick();
    idle();
    #1;
    chk("drain1_pc_enable", pc0, 0);
    chk("drain1_halted", h0, 0);
    tick();
    #1;
    chk("drain2_halted", h0, 0);
    tick();
    #1;
    chk("halted_after_3", h0, 1);
    chk("halted_pc_enable", pc0, 0);
    br = 1'b1; tgt = 8'h44;
    #1;
    chk("halted_ignores_br", js0, 0);
    chk("halted_br_pc_enable", pc0, 0);
    tick();
    idle();
    #1;
    chk("halted_stays", h0, 1);
    chk("halted_flush_count", fc0, 2);

    // Reset in the middle of DRAIN
    do_reset();
    hlt = 1'b1;
    tick();
    idle();
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_pc_enable", pc0, 0);
    chk("mid_rst_if_id_enable", ie0, 0);
    chk("mid_rst_bubble", bb0, 0);
    chk("mid_rst_stall_count", sc0, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_pc_enable", pc0, 1);
    chk("post_rst_counts", {sc0, fc0}, 0);
    tick(); tick(); tick();
    chk("post_rst_not_halted", h0, 0);

    // Branch on the second DRAIN cycle cancels the drain
    hlt = 1'b1;
    tick();
    idle();
    tick();
    br = 1'b1; tgt = 8'h10;
    #1;
    chk("drain_br_address", ja0, 8'h10);
    chk("drain_br_pc_enable", pc0, 1);
    tick();
    idle();
    #1;
    chk("drain_br_run", pc0, 1);
    tick(); tick(); tick();
    chk("drain_br_never_halted", h0, 0);

    // 20 back-to-back redirects against a 4-bit counter
    do_reset();
    br = 1'b1; tgt = 8'h01;
    for (int i = 0; i < 14; i++) tick();
    #1;
    chk("sat_before", fc2, 14);
    for (int i = 0; i < 6; i++) tick();
    #1;
    chk("sat_holds_15", fc2, 15);
    chk("wide_flush_20", fc0, 20);
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
